// File: rtl/cordic_rad2deg.sv
// Radian-to-degree converter behind the CORDIC arcsin/arccos stage (Q2.14 -> Q10.6).
// CORDIC_RAD2DEG_ROUND_EN selects round-half-up instead of truncation.
module cordic_rad2deg #(
    parameter int          n     = 16,
    parameter logic [15:0] KDEG  = 16'd58671,
    parameter int          SHIFT = 18
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         done_in,
    input  logic [n-1:0] asin_in,
    input  logic [n-1:0] acos_in,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [n-1:0] asin_deg,
    output logic [n-1:0] acos_deg,
    output logic         busy,
    output logic         overrun
);

`ifdef CORDIC_RAD2DEG_ROUND_EN
    localparam logic [33:0] R = 34'd1 << (SHIFT - 1);
`else
    localparam logic [33:0] R = 34'd0;
`endif

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t      state;
    logic [16:0] asin_mag;
    logic        asin_neg;
    logic [16:0] acos_mag;
    logic [32:0] acc_a;
    logic [32:0] acc_c;
    logic [3:0]  cnt;

    logic [16:0]  in_sx;
    logic [16:0]  in_mag;
    logic [32:0]  acc_a_nx;
    logic [32:0]  acc_c_nx;
    logic [n-1:0] asin_q;
    logic [n-1:0] acos_q;

    // Sign-extend to 17 bits so -32768 has a representable magnitude.
    always_comb begin
        in_sx  = {asin_in[n-1], asin_in};
        in_mag = in_sx[16] ? (17'd0 - in_sx) : in_sx;
    end

    // Include the current iteration so the last CALC edge finishes directly.
    always_comb begin
        acc_a_nx = acc_a;
        acc_c_nx = acc_c;
        if (KDEG[cnt]) begin
            acc_a_nx = acc_a + ({16'd0, asin_mag} << cnt);
            acc_c_nx = acc_c + ({16'd0, acos_mag} << cnt);
        end
        asin_q = n'(({1'b0, acc_a_nx} + R) >> SHIFT);
        acos_q = n'(({1'b0, acc_c_nx} + R) >> SHIFT);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            asin_mag  <= '0;
            asin_neg  <= 1'b0;
            acos_mag  <= '0;
            acc_a     <= '0;
            acc_c     <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            asin_deg  <= '0;
            acos_deg  <= '0;
            overrun   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (done_in) begin
                        asin_mag <= in_mag;
                        asin_neg <= asin_in[n-1];
                        acos_mag <= {1'b0, acos_in};
                        acc_a    <= '0;
                        acc_c    <= '0;
                        cnt      <= '0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    acc_a <= acc_a_nx;
                    acc_c <= acc_c_nx;
                    cnt   <= cnt + 4'd1;
                    if (done_in)
                        overrun <= 1'b1;
                    if (cnt == 4'd15) begin
                        asin_deg  <= asin_neg ? (n'(0) - asin_q) : asin_q;
                        acos_deg  <= acos_q;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (done_in) begin
                            asin_mag <= in_mag;
                            asin_neg <= asin_in[n-1];
                            acos_mag <= {1'b0, acos_in};
                            acc_a    <= '0;
                            acc_c    <= '0;
                            cnt      <= '0;
                            state    <= CALC;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (done_in) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_rad2deg.sv
// Randomized self-checking bench for cordic_rad2deg against an arithmetic model.
// Expected values follow CORDIC_RAD2DEG_ROUND_EN when it is defined.
module tb_cordic_rad2deg;

    logic        clk;
    logic        rst_n;
    logic        done_in;
    logic [15:0] asin_in;
    logic [15:0] acos_in;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] asin_deg;
    logic [15:0] acos_deg;
    logic        busy;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    cordic_rad2deg dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .done_in   (done_in),
        .asin_in   (asin_in),
        .acos_in   (acos_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .asin_deg  (asin_deg),
        .acos_deg  (acos_deg),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // degrees = radians * 180/pi, scaled Q14 -> Q6 through the 2^10 constant
    function automatic logic [15:0] ref_deg(input logic [15:0] x, input bit sgn);
        longint m;
        longint p;
        bit     neg;
        m   = sgn ? longint'($signed(x)) : longint'(x);
        neg = (m < 0);
        if (neg) m = -m;
        p = m * 58671;
`ifdef CORDIC_RAD2DEG_ROUND_EN
        p = p + 131072;
`endif
        p = p / 262144;
        if (neg) p = -p;
        return p[15:0];
    endfunction

    // Pulse done_in, count edges to out_valid, optionally transfer after a delay.
    task automatic convert(input logic [15:0] a, input logic [15:0] c,
                           input int wait_cyc, input bit xfer,
                           output int lat, output logic [15:0] ga,
                           output logic [15:0] gc);
        asin_in = a;
        acos_in = c;
        done_in = 1'b1;
        @(posedge clk);
        #1 done_in = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        ga = asin_deg;
        gc = acos_deg;
        if (xfer) begin
            repeat (wait_cyc) @(posedge clk);
            #1 out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, busy, overrun, asin_deg, acos_deg} !== 35'd0) begin
            errors++;
            $display("FAIL reset: got v=%b b=%b o=%b a=%h c=%h want all zero",
                     out_valid, busy, overrun, asin_deg, acos_deg);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_vectors;
        logic [15:0] va [7] = '{16'd25736, -16'sd12868, 16'd16384, -16'sd16384,
                                16'h8000, 16'h7FFF, 16'd0};
        logic [15:0] vc [7] = '{16'd0, 16'd51472, 16'd16384, 16'd100,
                                16'hFFFF, 16'd1, 16'd25736};
        int lat;
        logic [15:0] ga, gc;
        for (int i = 0; i < 7; i++) begin
            convert(va[i], vc[i], 0, 1'b1, lat, ga, gc);
            checks++;
            if (lat !== 16 || ga !== ref_deg(va[i], 1'b1) || gc !== ref_deg(vc[i], 1'b0)) begin
                errors++;
                $display("FAIL vec%0d: got lat=%0d a=%h c=%h want lat=16 a=%h c=%h",
                         i, lat, ga, gc, ref_deg(va[i], 1'b1), ref_deg(vc[i], 1'b0));
            end
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL vec_idle: got v=%b b=%b want 0 0", out_valid, busy);
        end
    endtask

    task automatic test_random;
        logic [15:0] a, c, ga, gc;
        int lat;
        for (int i = 0; i < 24; i++) begin
            a = 16'($urandom);
            c = 16'($urandom);
            convert(a, c, $urandom_range(0, 3), 1'b1, lat, ga, gc);
            checks++;
            if (lat !== 16 || ga !== ref_deg(a, 1'b1) || gc !== ref_deg(c, 1'b0)) begin
                errors++;
                $display("FAIL rand%0d in=%h/%h: got lat=%0d a=%h c=%h want 16 a=%h c=%h",
                         i, a, c, lat, ga, gc, ref_deg(a, 1'b1), ref_deg(c, 1'b0));
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] ga, gc;
        int lat;
        convert(16'd25736, 16'd0, 0, 1'b0, lat, ga, gc);
        asin_in   = -16'sd12868;
        acos_in   = 16'd51472;
        done_in   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 done_in = 1'b0;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_xfer: got v=%b b=%b want v=0 b=1", out_valid, busy);
        end
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        checks++;
        if (lat !== 16 || asin_deg !== 16'hF4C0 || acos_deg !== 16'h2D00 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result: got lat=%0d a=%h c=%h o=%b want 16 F4C0 2D00 0",
                     lat, asin_deg, acos_deg, overrun);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_hold_overrun;
        logic [15:0] ga, gc;
        int lat;
        bit bad;
        convert(16'd16384, 16'd51472, 0, 1'b0, lat, ga, gc);
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                asin_in = 16'd1000;
                acos_in = 16'd2000;
                done_in = 1'b1;
            end
            @(posedge clk);
            #1 done_in = 1'b0;
            if (!out_valid || asin_deg !== ga || acos_deg !== gc) bad = 1'b1;
        end
        checks++;
        if (bad || ga !== ref_deg(16'd16384, 1'b1) || gc !== 16'h2D00) begin
            errors++;
            $display("FAIL hold_stable: got v=%b a=%h c=%h want v=1 a=%h c=2d00",
                     out_valid, asin_deg, acos_deg, ref_deg(16'd16384, 1'b1));
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b want 1", overrun);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL hold_xfer: got v=%b b=%b o=%b want 0 0 1", out_valid, busy, overrun);
        end
    endtask

    task automatic test_reset_mid_calc;
        logic [15:0] ga, gc;
        int lat;
        asin_in = 16'd5000;
        acos_in = 16'd6000;
        done_in = 1'b1;
        @(posedge clk);
        #1 done_in = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, overrun, asin_deg, acos_deg} !== 35'd0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b b=%b o=%b a=%h c=%h want all zero",
                     out_valid, busy, overrun, asin_deg, acos_deg);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        convert(-16'sd16384, 16'd12345, 1, 1'b1, lat, ga, gc);
        checks++;
        if (lat !== 16 || ga !== ref_deg(-16'sd16384, 1'b1) || gc !== ref_deg(16'd12345, 1'b0)) begin
            errors++;
            $display("FAIL post_reset: got lat=%0d a=%h c=%h want 16 a=%h c=%h",
                     lat, ga, gc, ref_deg(-16'sd16384, 1'b1), ref_deg(16'd12345, 1'b0));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        done_in   = 1'b0;
        asin_in   = '0;
        acos_in   = '0;
        out_ready = 1'b0;
        test_reset();
        test_vectors();
        test_random();
        test_back_to_back();
        test_hold_overrun();
        test_reset_mid_calc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
